// File: rtl/mem_bank_responder_pkg.sv
// Shared types for the memory bank responder: access width, FSM state and
// the bank-touch helper used by the read and write address decode.
package mem_bank_responder_pkg;

    typedef enum logic {
        SINGLE_WIDTH = 1'b0,
        DOUBLE_WIDTH = 1'b1
    } DataWidth_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } MemBankState_t;

    // Banks touched by an access; a double access always spans both banks.
    function automatic logic [1:0] bank_mask(input logic addr_lsb, input DataWidth_t width);
        logic [1:0] mask;
        mask = 2'b00;
        if (width == DOUBLE_WIDTH) begin
            mask = 2'b11;
        end else if (addr_lsb) begin
            mask = 2'b10;
        end else begin
            mask = 2'b01;
        end
        return mask;
    endfunction

endpackage

// File: rtl/mem_bank_responder_read_pipe.sv
// Read return pipe: carries valid/width/low-bank select alongside the bank
// access and assembles rd_data from the two bank outputs one cycle later.
module mem_bank_responder_read_pipe
    import mem_bank_responder_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    input  DataWidth_t             issue_width,
    input  logic                   issue_lo_bank,
    input  logic [1:0][DATA_W-1:0] bank_rdata,
    output logic [2*DATA_W-1:0]    rd_data,
    output logic                   rd_valid
);

    logic                s1_valid;
    DataWidth_t          s1_width;
    logic                s1_lo_bank;
    logic                s1_hi_bank;
    logic [DATA_W-1:0]   lo_word;
    logic [DATA_W-1:0]   hi_word;
    logic [2*DATA_W-1:0] assembled;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_width   <= SINGLE_WIDTH;
            s1_lo_bank <= 1'b0;
        end else begin
            s1_valid   <= issue_valid;
            s1_width   <= issue_width;
            s1_lo_bank <= issue_lo_bank;
        end
    end

    // Bank data is valid during the stage-1 cycle; pick words by bank select.
    always_comb begin
        s1_hi_bank = ~s1_lo_bank;
        lo_word    = bank_rdata[s1_lo_bank];
        hi_word    = bank_rdata[s1_hi_bank];
        assembled  = '0;
        if (s1_width == DOUBLE_WIDTH) begin
            assembled = {hi_word, lo_word};
        end else begin
            assembled = {{DATA_W{1'b0}}, lo_word};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= s1_valid;
            if (s1_valid) begin
                rd_data <= assembled;
            end
        end
    end

endmodule

// File: rtl/mem_bank_responder.sv
// Responder for one reader and one writer over two word-interleaved SRAM
// banks; writes win bank conflicts and the losing read waits in a pending slot.
module mem_bank_responder
    import mem_bank_responder_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int BANK_DEPTH = 512,
    parameter int ADDR_W     = $clog2(2 * BANK_DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 rd_en,
    input  logic [ADDR_W-1:0]                    rd_addr,
    input  DataWidth_t                           rd_width,
    output logic [2*DATA_W-1:0]                  rd_data,
    output logic                                 rd_valid,
    output logic                                 rd_stall,
    input  logic                                 wr_en,
    input  logic                                 wr_chip_en,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  DataWidth_t                           wr_width,
    input  logic [2*DATA_W-1:0]                  wr_data,
    output logic [1:0]                           bank_en,
    output logic [1:0]                           bank_chip_en,
    output logic [1:0][$clog2(BANK_DEPTH)-1:0]   bank_addr,
    output logic [1:0][DATA_W-1:0]               bank_wdata,
    input  logic [1:0][DATA_W-1:0]               bank_rdata,
    output logic                                 err_rd_overrun,
    output MemBankState_t                        dbg_state
);

    localparam int ROW_W = $clog2(BANK_DEPTH);

    MemBankState_t     state;
    MemBankState_t     state_nxt;
    logic [ADDR_W-1:0] pend_addr;
    DataWidth_t        pend_width;

    logic              wr_do;
    logic [1:0]        wr_mask;
    logic [ADDR_W-1:0] wr_hi_addr;
    logic              wr_lo_bank;
    logic [ROW_W-1:0]  wr_lo_row;
    logic [ROW_W-1:0]  wr_hi_row;

    logic              rd_take;
    logic              cand_valid;
    logic [ADDR_W-1:0] cand_addr;
    DataWidth_t        cand_width;
    logic [ADDR_W-1:0] cand_hi_addr;
    logic              cand_lo_bank;
    logic [ROW_W-1:0]  cand_lo_row;
    logic [ROW_W-1:0]  cand_hi_row;
    logic [1:0]        rd_mask;
    logic              conflict;
    logic              rd_issue;

    assign rd_stall  = (state == PENDING);
    assign dbg_state = state;

    // Write decode: the high word of a double access wraps modulo the address space.
    assign wr_do      = wr_en & wr_chip_en;
    assign wr_mask    = wr_do ? bank_mask(wr_addr[0], wr_width) : 2'b00;
    assign wr_hi_addr = wr_addr + ADDR_W'(1);
    assign wr_lo_bank = wr_addr[0];
    assign wr_lo_row  = wr_addr[ADDR_W-1:1];
    assign wr_hi_row  = wr_hi_addr[ADDR_W-1:1];

    // A held read takes precedence over new requests, which are dropped while stalled.
    assign rd_take      = rd_en & ~rd_stall;
    assign cand_valid   = rd_stall | rd_take;
    assign cand_addr    = rd_stall ? pend_addr : rd_addr;
    assign cand_width   = rd_stall ? pend_width : rd_width;
    assign cand_hi_addr = cand_addr + ADDR_W'(1);
    assign cand_lo_bank = cand_addr[0];
    assign cand_lo_row  = cand_addr[ADDR_W-1:1];
    assign cand_hi_row  = cand_hi_addr[ADDR_W-1:1];
    assign rd_mask      = cand_valid ? bank_mask(cand_addr[0], cand_width) : 2'b00;

    assign conflict = |(wr_mask & rd_mask);
    assign rd_issue = cand_valid & ~conflict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_take && conflict) state_nxt = PENDING;
            PENDING: if (!conflict) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_addr  <= '0;
            pend_width <= SINGLE_WIDTH;
        end else if (state == IDLE && rd_take && conflict) begin
            pend_addr  <= rd_addr;
            pend_width <= rd_width;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_rd_overrun <= 1'b0;
        end else if (rd_en && rd_stall) begin
            err_rd_overrun <= 1'b1;
        end
    end

    // Per-bank port drive: a performed write owns its banks, the read gets the rest.
    always_comb begin
        bank_en      = 2'b00;
        bank_chip_en = 2'b00;
        bank_addr    = '0;
        bank_wdata   = '0;
        for (int b = 0; b < 2; b++) begin
            if (wr_mask[b]) begin
                bank_en[b]      = 1'b1;
                bank_chip_en[b] = 1'b1;
                if (1'(b) == wr_lo_bank) begin
                    bank_addr[b]  = wr_lo_row;
                    bank_wdata[b] = wr_data[DATA_W-1:0];
                end else begin
                    bank_addr[b]  = wr_hi_row;
                    bank_wdata[b] = wr_data[2*DATA_W-1:DATA_W];
                end
            end else if (rd_issue && rd_mask[b]) begin
                bank_en[b]   = 1'b1;
                bank_addr[b] = (1'(b) == cand_lo_bank) ? cand_lo_row : cand_hi_row;
            end
        end
    end

    mem_bank_responder_read_pipe #(
        .DATA_W (DATA_W)
    ) u_read_pipe (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (rd_issue),
        .issue_width   (cand_width),
        .issue_lo_bank (cand_lo_bank),
        .bank_rdata    (bank_rdata),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid)
    );

endmodule

// File: tb/tb_mem_bank_responder.sv
// Bench for mem_bank_responder: SRAM bank models, a flat word-memory reference
// model with a pending-read slot, directed scenarios, then randomized traffic.
module tb_mem_bank_responder;
  import mem_bank_responder_pkg::*;

  localparam int DATA_W = 16;
  localparam int BANK_DEPTH = 512;
  localparam int ADDR_W = 10;
  localparam int WORDS = 2 * BANK_DEPTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic rd_en, wr_en, wr_chip_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  DataWidth_t rd_width, wr_width;
  logic [2*DATA_W-1:0] wr_data, rd_data;
  logic rd_valid, rd_stall, err_rd_overrun;
  logic [1:0] bank_en, bank_chip_en;
  logic [1:0][8:0] bank_addr;
  logic [1:0][DATA_W-1:0] bank_wdata;
  logic [1:0][DATA_W-1:0] bank_rdata;
  MemBankState_t dbg_state;

  mem_bank_responder #(
    .DATA_W(DATA_W), .BANK_DEPTH(BANK_DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_width(rd_width),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_stall(rd_stall),
    .wr_en(wr_en), .wr_chip_en(wr_chip_en), .wr_addr(wr_addr),
    .wr_width(wr_width), .wr_data(wr_data),
    .bank_en(bank_en), .bank_chip_en(bank_chip_en), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
    .err_rd_overrun(err_rd_overrun), .dbg_state(dbg_state)
  );

  // Single-port SRAM bank macros, read data one cycle after enable.
  logic [DATA_W-1:0] sram [2][BANK_DEPTH];
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (bank_en[b]) begin
        if (bank_chip_en[b]) sram[b][bank_addr[b]] <= bank_wdata[b];
        else bank_rdata[b] <= sram[b][bank_addr[b]];
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [DATA_W-1:0] mem_m [WORDS];
  logic [2*DATA_W-1:0] exp_q[$];
  int due_q[$];
  bit m_pend;
  int m_pend_addr;
  DataWidth_t m_pend_w;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Banks touched, from the parity of every word an access covers.
  function automatic logic [1:0] touched(input int a, input DataWidth_t w);
    logic [1:0] m;
    m = 2'b00;
    m[a % 2] = 1'b1;
    if (w == DOUBLE_WIDTH) m[((a + 1) % WORDS) % 2] = 1'b1;
    return m;
  endfunction

  task automatic model_step();
    logic [1:0] wmask;
    bit have;
    int a;
    DataWidth_t w;
    wmask = (wr_en && wr_chip_en) ? touched(int'(wr_addr), wr_width) : 2'b00;
    if (rd_en && m_pend) m_err = 1'b1;
    have = m_pend || rd_en;
    a = m_pend ? m_pend_addr : int'(rd_addr);
    w = m_pend ? m_pend_w : rd_width;
    if (have) begin
      if ((wmask & touched(a, w)) != 2'b00) begin
        m_pend = 1'b1;
        m_pend_addr = a;
        m_pend_w = w;
      end else begin
        if (w == DOUBLE_WIDTH) exp_q.push_back({mem_m[(a + 1) % WORDS], mem_m[a]});
        else exp_q.push_back({16'h0000, mem_m[a]});
        due_q.push_back(cyc + 2);
        m_pend = 1'b0;
      end
    end
    if (wmask != 2'b00) begin
      mem_m[wr_addr] = wr_data[15:0];
      if (wr_width == DOUBLE_WIDTH) mem_m[(int'(wr_addr) + 1) % WORDS] = wr_data[31:16];
    end
  endtask

  task automatic check_outputs();
    bit exp_v;
    exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
    check("rd_valid", 32'(rd_valid), 32'(exp_v));
    if (exp_v) begin
      check("rd_data", rd_data, exp_q[0]);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
    check("rd_stall", 32'(rd_stall), 32'(m_pend));
    check("dbg_state", 32'(dbg_state), 32'(m_pend));
    check("err_rd_overrun", 32'(err_rd_overrun), 32'(m_err));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic ren, input int raddr, input DataWidth_t rw,
                            input logic wen, input logic wce, input int waddr,
                            input DataWidth_t ww, input logic [31:0] wdat);
    rd_en = ren; rd_addr = ADDR_W'(raddr); rd_width = rw;
    wr_en = wen; wr_chip_en = wce; wr_addr = ADDR_W'(waddr); wr_width = ww; wr_data = wdat;
    #1;
  endtask

  task automatic set_idle();
    set_inputs(1'b0, 0, SINGLE_WIDTH, 1'b0, 1'b0, 0, SINGLE_WIDTH, 32'h0);
  endtask

  task automatic run_cycle();
    if (rst_n) model_step();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic do_reset_clear();
    exp_q.delete();
    due_q.delete();
    m_pend = 1'b0;
    m_err = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < BANK_DEPTH; r++) sram[b][r] = '0;
    for (int i = 0; i < WORDS; i++) mem_m[i] = '0;
    bank_rdata = '0;
    do_reset_clear();
    set_idle();
    @(negedge clk);
    run_cycle();
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_bank_en", 32'(bank_en), 32'h0);
    rst_n = 1'b1;
    run_cycle();

    // Single read of bank 1 row 2.
    set_inputs(1'b0, 0, SINGLE_WIDTH, 1'b1, 1'b1, 5, SINGLE_WIDTH, 32'h0000_1234);
    check("wr5_bank_en", 32'(bank_en), 32'h2);
    check("wr5_chip_en", 32'(bank_chip_en), 32'h2);
    check("wr5_row", 32'(bank_addr[1]), 32'd2);
    run_cycle();
    set_inputs(1'b1, 5, SINGLE_WIDTH, 1'b0, 1'b0, 0, SINGLE_WIDTH, 32'h0);
    run_cycle();
    set_idle();
    run_cycle();
    check("single_rd_valid", 32'(rd_valid), 32'h1);
    check("single_rd_data", rd_data, 32'h0000_1234);

    // Double read at an odd address spans bank1 row3 and bank0 row4.
    set_inputs(1'b0, 0, SINGLE_WIDTH, 1'b1, 1'b1, 7, SINGLE_WIDTH, 32'h0000_AAAA);
    run_cycle();
    set_inputs(1'b0, 0, SINGLE_WIDTH, 1'b1, 1'b1, 8, SINGLE_WIDTH, 32'h0000_BBBB);
    run_cycle();
    set_inputs(1'b1, 7, DOUBLE_WIDTH, 1'b0, 1'b0, 0, SINGLE_WIDTH, 32'h0);
    check("dbl_bank_en", 32'(bank_en), 32'h3);
    check("dbl_chip_en", 32'(bank_chip_en), 32'h0);
    check("dbl_row_b1", 32'(bank_addr[1]), 32'd3);
    check("dbl_row_b0", 32'(bank_addr[0]), 32'd4);
    run_cycle();
    set_idle();
    run_cycle();
    check("dbl_rd_data", rd_data, 32'hBBBB_AAAA);

    // Wrap: high word of address 1023 lands in bank0 row0.
    set_inputs(1'b0, 0, SINGLE_WIDTH, 1'b1, 1'b1, 1023, DOUBLE_WIDTH, 32'hDEAD_BEEF);
    check("wrap_row_b1", 32'(bank_addr[1]), 32'd511);
    check("wrap_row_b0", 32'(bank_addr[0]), 32'd0);
    check("wrap_wdata_b1", 32'(bank_wdata[1]), 32'hBEEF);
    check("wrap_wdata_b0", 32'(bank_wdata[0]), 32'hDEAD);
    run_cycle();
    check("wrap_sram_b1", 32'(sram[1][511]), 32'hBEEF);
    check("wrap_sram_b0", 32'(sram[0][0]), 32'hDEAD);
    set_inputs(1'b1, 1023, DOUBLE_WIDTH, 1'b0, 1'b0, 0, SINGLE_WIDTH, 32'h0);
    run_cycle();
    set_idle();
    run_cycle();
    check("wrap_rd_data", rd_data, 32'hDEAD_BEEF);

    // Bank-0 conflict: write wins, read issues one cycle late.
    set_inputs(1'b1, 6, SINGLE_WIDTH, 1'b1, 1'b1, 4, SINGLE_WIDTH, 32'h0000_5555);
    run_cycle();
    check("conflict_stall", 32'(rd_stall), 32'h1);
    set_idle();
    repeat (3) run_cycle();

    // Three back-to-back bank-0 writes hold the read for three cycles.
    set_inputs(1'b1, 2, SINGLE_WIDTH, 1'b1, 1'b1, 0, SINGLE_WIDTH, 32'h0000_1111);
    run_cycle();
    set_inputs(1'b0, 0, SINGLE_WIDTH, 1'b1, 1'b1, 10, SINGLE_WIDTH, 32'h0000_2222);
    run_cycle();
    set_inputs(1'b0, 0, SINGLE_WIDTH, 1'b1, 1'b1, 2, SINGLE_WIDTH, 32'h0000_3333);
    run_cycle();
    check("stall_3rd", 32'(rd_stall), 32'h1);
    set_idle();
    repeat (3) run_cycle();

    // Disjoint banks proceed together; a write without chip enable is a no-op.
    set_inputs(1'b1, 1, SINGLE_WIDTH, 1'b1, 1'b1, 0, SINGLE_WIDTH, 32'h0000_7777);
    run_cycle();
    check("disjoint_no_stall", 32'(rd_stall), 32'h0);
    set_inputs(1'b1, 0, SINGLE_WIDTH, 1'b1, 1'b0, 0, SINGLE_WIDTH, 32'h0000_9999);
    check("noce_bank_chip_en", 32'(bank_chip_en), 32'h0);
    run_cycle();
    set_idle();
    repeat (2) run_cycle();

    // Overrun: rd_en while stalled is dropped and latches the error.
    set_inputs(1'b1, 2, SINGLE_WIDTH, 1'b1, 1'b1, 0, SINGLE_WIDTH, 32'h0000_4444);
    run_cycle();
    set_inputs(1'b1, 3, SINGLE_WIDTH, 1'b1, 1'b1, 4, SINGLE_WIDTH, 32'h0000_6666);
    run_cycle();
    set_idle();
    repeat (4) run_cycle();
    check("overrun_sticky", 32'(err_rd_overrun), 32'h1);

    // Reset one cycle after a read issues: its result never appears.
    set_inputs(1'b1, 5, SINGLE_WIDTH, 1'b0, 1'b0, 0, SINGLE_WIDTH, 32'h0);
    run_cycle();
    set_idle();
    rst_n = 1'b0;
    do_reset_clear();
    #1;
    check("rst_bank_en", 32'(bank_en), 32'h0);
    check("rst_stall", 32'(rd_stall), 32'h0);
    check("rst_err", 32'(err_rd_overrun), 32'h0);
    repeat (3) run_cycle();
    rst_n = 1'b1;
    repeat (2) run_cycle();

    // Randomized traffic, biased toward a small window to provoke conflicts.
    for (int i = 0; i < 2000; i++) begin
      logic ren, wen, wce;
      int ra, wa;
      DataWidth_t rw, ww;
      ren = !m_pend && ($urandom_range(0, 1) == 1);
      wen = ($urandom_range(0, 2) != 0);
      wce = ($urandom_range(0, 4) != 0);
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WORDS - 1)) : int'($urandom_range(0, 15));
      wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WORDS - 1)) : int'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) ra = WORDS - 1;
      rw = DataWidth_t'($urandom_range(0, 1));
      ww = DataWidth_t'($urandom_range(0, 1));
      set_inputs(ren, ra, rw, wen, wce, wa, ww, $urandom());
      run_cycle();
    end
    set_idle();
    repeat (4) run_cycle();
    check("drain_empty", 32'(due_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bank_responder.md
Name: mem_bank_responder

Overview:
- Responder end of the centralized memory interface: services one read requester and one writer against two interleaved single-port SRAM banks.
- The bank macros are outside this block; it drives their bank-level ports.
- Handles single- and double-width accesses, read-latency pipelining, and read/write bank conflicts.
- Sits between the compute datapath's memory interface and the bank macros.

Parameters:
- DATA_W, 16, width of one stored word.
- BANK_DEPTH, 512, words per bank.
- ADDR_W, $clog2(2*BANK_DEPTH), width of the word address seen by requesters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_en  in  1  read request strobe.
- rd_addr  in  ADDR_W  read word address.
- rd_width  in  DataWidth_t  SINGLE_WIDTH or DOUBLE_WIDTH.
- rd_data  out  2*DATA_W  read result.
- rd_valid  out  1  one-cycle pulse when rd_data is valid.
- rd_stall  out  1  pending read held; requester must not issue.
- wr_en  in  1  write strobe.
- wr_chip_en  in  1  write qualifier.
- wr_addr  in  ADDR_W  write word address.
- wr_width  in  DataWidth_t  write width.
- wr_data  in  2*DATA_W  write data; low word in [DATA_W-1:0].
- bank_en[1:0]  out  2  per-bank access enable.
- bank_chip_en[1:0]  out  2  per-bank write enable.
- bank_addr[1:0]  out  2 x $clog2(BANK_DEPTH)  per-bank row address.
- bank_wdata[1:0]  out  2 x DATA_W  per-bank write data.
- bank_rdata[1:0]  in  2 x DATA_W  per-bank read data, 1 cycle after bank_en.
- err_rd_overrun  out  1  sticky; set when rd_en arrives while rd_stall is high.

Behaviour:
- Address mapping:
  - bank = addr[0]; row = addr >> 1.
  - A double-width access covers word addr (low) and addr+1 (high), computed modulo 2*BANK_DEPTH. Address 2*BANK_DEPTH-1 wraps its high word to address 0.
  - A double access always touches both banks.
- Write handling:
  - A write is performed only when wr_en & wr_chip_en.
  - Bank signals are driven combinationally in the same cycle.
  - wr_en without wr_chip_en is a no-op.
- Read issue:
  - The read is issued to its banks in cycle T.
  - bank_rdata is captured at T+1 and registered into rd_data.
  - rd_valid pulses at T+2, so latency is 2 cycles. Back-to-back reads give one result per cycle.
- Read result formatting:
  - Width and bank-select are carried down the pipe with the request.
  - SINGLE: rd_data = zero-extended word.
  - DOUBLE: rd_data = {word(addr+1), word(addr)}.
- Conflicts:
  - A read and a performed write that share a bank in the same cycle: the write wins.
  - The read is captured into a one-entry pending register.
- FSM states:
  - IDLE → PENDING on a conflict.
  - PENDING → IDLE when the pending read issues, i.e. no conflicting write in that cycle.
  - PENDING stays PENDING while the conflict persists; writes always keep priority.
- Stall and overrun:
  - rd_stall is registered and is high exactly in PENDING.
  - rd_en while rd_stall is high is dropped and sets err_rd_overrun. err_rd_overrun clears only on reset.
- Non-conflicting traffic:
  - A read and a write to disjoint banks proceed in the same cycle.
  - Same-address read-after-write in the same cycle is a conflict, so the read returns the new data.
- Reset values:
  - All outputs 0; FSM to IDLE; pending entry and read pipe cleared.
  - Reset mid-read discards in-flight results; no rd_valid follows reset.

Decomposition:
- Package (Defines):
  - DataWidth_t, already shared.
  - Add MemBankState_t {IDLE, PENDING}.
  - Add a bank-select helper function.
- Natural sub-module: mem_bank_read_pipe.
  - Two-stage valid/width/bank-select shift register plus rd_data assembly mux.
  - Instantiated once.

Test Plan:
- Single read: write 0x1234 to addr 5 (bank 1, row 2); read addr 5 at cycle T → rd_valid at T+2, rd_data=0x00001234.
- Double read at odd address: write 0xAAAA@7, 0xBBBB@8; DOUBLE read addr 7 → bank1 row3 and bank0 row4 enabled same cycle; rd_data=0xBBBBAAAA after 2 cycles.
- Wrap: DOUBLE write 0xDEADBEEF to addr 1023 → bank1 row511=0xBEEF, bank0 row0=0xDEAD; DOUBLE read 1023 returns 0xDEADBEEF.
- Conflict: same-cycle SINGLE write 0x5555@4 and read @6 (both bank 0):
  - Write performed; rd_stall=1 next cycle.
  - Read issues next cycle; rd_valid 3 cycles after the request.
  - Repeat with 3 consecutive bank-0 writes → stall persists 3 cycles.
- Overrun and disjoint: rd_en during rd_stall → dropped, err_rd_overrun=1 until reset. Read bank 1 + write bank 0 same cycle → no stall, latency 2.
- Reset mid-operation:
  - Deassert rst_n one cycle after a read issues → rd_valid stays 0.
  - rd_stall=0, all bank_en=0; err_rd_overrun cleared.
